seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display that shares one combinational hex-to-segment decoder (nibble in, segments a..g out) across all digits. It holds a double-buffered digit register, walks the digits at a programmable slot rate, presents each digit's nibble to the shared decoder, registers the returned segment pattern and drives the active-low digit enables with anti-ghosting blanking. It sits between the register/bus side that writes display values and the display-pin outputs.

---
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One combinational hex-to-segment decoder outside this block is
// shared by all digits: the block presents the nibble of the digit being
// scanned on dec_in, registers the decoder's answer into seg, and drives the
// active-low digit enables. Every slot starts with a few blanked cycles so the
// new segment pattern settles before its digit is switched on.
//
// Display values are double-buffered. A bus write lands in the shadow copy and
// is moved to the active copy only on the last cycle of a frame, or at once
// while the scanner is parked, so a frame never shows a mix of old and new
// digits.
//
// Ports
//   clk      in   rising-edge clock
//   nrst     in   synchronous active-low reset
//   en       in   scan enable; low blanks the display and parks the scanner
//   wr       in   load strobe for wdata, sampled every cycle
//   wdata    in   4*DIGITS bits, nibble k = digit k
//   pending  out  shadow holds a value not yet shown
//   dec_in   out  nibble to the shared decoder (from registers)
//   dec_seg  in   decoder result {a..g}, combinational from dec_in
//   seg      out  registered segment drive {a..g}, active-high
//   an       out  DIGITS digit enables, active-low, at most one low
//   frame    out  one-cycle pulse on the last cycle of the last digit's slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 2
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  wr,
   input  logic [4*DIGITS-1:0]   wdata,
   output logic                  pending,
   output logic [3:0]            dec_in,
   input  logic [6:0]            dec_seg,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t                   state;
   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [CW-1:0]            cnt_inc;
   logic [IW-1:0]            idx_inc;
   logic [DIGITS-1:0][3:0]   shadow;
   logic [DIGITS-1:0][3:0]   active;
   logic                     xfer;

   assign cnt_inc = cnt + 1'b1;
   assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

   // The shared decoder sees the active nibble of the current digit.
   assign dec_in = active[idx];

   // ---------------------------------------------------------------------------
   // Scan FSM. an and frame are registered and are computed here for the
   // state being entered, so they line up with state/cnt/idx on the same cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         seg   <= '0;
         an    <= '1;
         frame <= 1'b0;
      end else begin
         // seg tracks the decoder every cycle, even while parked, so the
         // first digit of a restarted scan already has a valid pattern.
         seg   <= dec_seg;
         an    <= '1;
         frame <= 1'b0;
         if (!en) begin
            // Abandon the slot; no frame pulse is produced.
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_BLANK;
                  cnt   <= '0;
                  idx   <= '0;
               end
               default: begin
                  if (cnt == CNT_LAST) begin
                     // Next slot always opens blanked (BLANK >= 1).
                     state <= S_BLANK;
                     cnt   <= '0;
                     idx   <= idx_inc;
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= CNT_SHOW) begin
                        state <= S_SHOW;
                        an    <= ~(DIGITS'(1) << idx);
                     end else begin
                        state <= S_BLANK;
                     end
                     if (idx == IDX_LAST && cnt_inc == CNT_LAST)
                        frame <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Double buffer. A transfer slot is the frame cycle or any parked cycle.
   // A write coinciding with a transfer goes straight to the active copy, so
   // pending never rises for it. Parked writes therefore show on the next
   // cycle.
   // ---------------------------------------------------------------------------
   assign xfer = frame || (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else if (xfer) begin
         if (wr) begin
            active <= wdata;
            shadow <= wdata;
         end else if (pending) begin
            active <= shadow;
         end
         pending <= 1'b0;
      end else if (wr) begin
         // Last write before the transfer wins.
         shadow  <= wdata;
         pending <= 1'b1;
      end
   end

endmodule
